// File: rtl/enable_arbiter_pkg.sv
// Shared types and default parameters for the two-requester enable arbiter.
package enable_arbiter_pkg;

    typedef enum logic [1:0] {
        PARK_1 = 2'd0,
        PARK_2 = 2'd1,
        BUSY_1 = 2'd2,
        BUSY_2 = 2'd3
    } state_t;

    localparam int DATA_W_DEF   = 8;
    localparam int LIMIT_DEF    = 200;
    localparam int MAX_HOLD_DEF = 4;

endpackage

// File: rtl/arb_hold_counter.sv
// Saturating hold-time counter: expired flags that the owner has held the
// resource for MAX_HOLD cycles counting the grant cycle.
module arb_hold_counter
    import enable_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] TOP = CW'(MAX_HOLD - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != TOP) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == TOP);

endmodule

// File: rtl/enable_arbiter.sv
// Round-robin arbiter keeping exactly one of enable_1/enable_2 high, with
// range-checked data forwarding and hold-time preemption.
module enable_arbiter
    import enable_arbiter_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LIMIT    = LIMIT_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_1,
    input  logic              req_2,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic              done,
    output logic              enable_1,
    output logic              enable_2,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              reject_1,
    output logic              reject_2
);

    localparam logic [DATA_W-1:0] LIMIT_V = DATA_W'(LIMIT);

    state_t            state, state_nx;
    logic [DATA_W-1:0] data_nx;
    logic              grant, stay, expired;
    logic              v_1, v_2, bad_1, bad_2;

    assign v_1   = req_1 && (data_1 <= LIMIT_V);
    assign v_2   = req_2 && (data_2 <= LIMIT_V);
    assign bad_1 = req_1 && (data_1 >  LIMIT_V);
    assign bad_2 = req_2 && (data_2 >  LIMIT_V);

    // NOTE: combinational logic uses blocking assignments with a default for
    // every output first, so no path leaves a value unassigned (no latch).
    always_comb begin
        state_nx = state;
        data_nx  = data_out;
        grant    = 1'b0;
        stay     = 1'b0;
        unique case (state)
            PARK_1: begin
                if (v_2) begin
                    state_nx = BUSY_2; data_nx = data_2; grant = 1'b1;
                end else if (v_1) begin
                    state_nx = BUSY_1; data_nx = data_1; grant = 1'b1;
                end
            end
            PARK_2: begin
                if (v_1) begin
                    state_nx = BUSY_1; data_nx = data_1; grant = 1'b1;
                end else if (v_2) begin
                    state_nx = BUSY_2; data_nx = data_2; grant = 1'b1;
                end
            end
            BUSY_1: begin
                if ((done || expired) && v_2) begin
                    state_nx = BUSY_2; data_nx = data_2; grant = 1'b1;
                end else if (done) begin
                    state_nx = PARK_1;
                end else begin
                    stay = 1'b1;
                end
            end
            BUSY_2: begin
                if ((done || expired) && v_1) begin
                    state_nx = BUSY_1; data_nx = data_1; grant = 1'b1;
                end else if (done) begin
                    state_nx = PARK_2;
                end else begin
                    stay = 1'b1;
                end
            end
            default: state_nx = PARK_1;
        endcase
    end

    arb_hold_counter #(.MAX_HOLD(MAX_HOLD)) u_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (grant),
        .enable  (stay),
        .expired (expired)
    );

    // Outputs are registered from the next state so the enables swap together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= PARK_1;
            data_out   <= '0;
            enable_1   <= 1'b1;
            enable_2   <= 1'b0;
            data_valid <= 1'b0;
            reject_1   <= 1'b0;
            reject_2   <= 1'b0;
        end else begin
            state      <= state_nx;
            data_out   <= data_nx;
            enable_1   <= (state_nx == PARK_1) || (state_nx == BUSY_1);
            enable_2   <= (state_nx == PARK_2) || (state_nx == BUSY_2);
            data_valid <= (state_nx == BUSY_1) || (state_nx == BUSY_2);
            reject_1   <= bad_1;
            reject_2   <= bad_2;
        end
    end

    a_one_hot: assert property (@(posedge clk) disable iff (!reset_n)
        enable_1 ^ enable_2);

    a_data_range: assert property (@(posedge clk) disable iff (!reset_n)
        data_valid |-> data_out <= LIMIT_V);

    // A rejected request must never have produced a grant to its own side.
    a_reject_1: assert property (@(posedge clk) disable iff (!reset_n)
        reject_1 |-> !(state == BUSY_1 && $past(state) != BUSY_1));

    a_reject_2: assert property (@(posedge clk) disable iff (!reset_n)
        reject_2 |-> !(state == BUSY_2 && $past(state) != BUSY_2));

endmodule

// File: tb/tb_enable_arbiter.sv
// Directed bench for enable_arbiter: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_enable_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_1, req_2, done;
    logic [7:0] data_1, data_2;
    logic       enable_1, enable_2, data_valid, reject_1, reject_2;
    logic [7:0] data_out;

    int n_checks = 0;
    int n_fails  = 0;

    enable_arbiter #(.DATA_W(8), .LIMIT(200), .MAX_HOLD(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_1      (req_1),
        .req_2      (req_2),
        .data_1     (data_1),
        .data_2     (data_2),
        .done       (done),
        .enable_1   (enable_1),
        .enable_2   (enable_2),
        .data_out   (data_out),
        .data_valid (data_valid),
        .reject_1   (reject_1),
        .reject_2   (reject_2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_en(input string tag, input logic e1, input logic e2, input logic dv);
        check({tag, ".enable_1"}, 32'(enable_1), 32'(e1));
        check({tag, ".enable_2"}, 32'(enable_2), 32'(e2));
        check({tag, ".data_valid"}, 32'(data_valid), 32'(dv));
    endtask

    initial begin
        reset_n = 1'b0;
        req_1 = 1'b0; req_2 = 1'b0; done = 1'b0;
        data_1 = 8'd0; data_2 = 8'd0;

        tick();
        check_en("reset", 1'b1, 1'b0, 1'b0);
        check("reset.data_out", 32'(data_out), 32'd0);
        check("reset.reject_2", 32'(reject_2), 32'd0);
        #2 reset_n = 1'b1;

        // 1: idle after reset stays parked on side 1
        for (int i = 0; i < 5; i++) begin
            tick();
            check_en("idle", 1'b1, 1'b0, 1'b0);
        end

        // 2: boundary value 200 is accepted, done returns to PARK_1
        req_1 = 1'b1; data_1 = 8'd200;
        tick();
        check_en("grant1", 1'b1, 1'b0, 1'b1);
        check("grant1.data_out", 32'(data_out), 32'd200);
        req_1 = 1'b0; done = 1'b1;
        tick();
        done = 1'b0;
        check_en("park1", 1'b1, 1'b0, 1'b0);
        check("park1.data_out", 32'(data_out), 32'd200);
        check("park1.reject_2", 32'(reject_2), 32'd0);

        // 3: out-of-range 210 on side 2 is rejected each cycle, one cycle late
        req_2 = 1'b1; data_2 = 8'd210;
        tick();
        check("rej_a.reject_2", 32'(reject_2), 32'd1);
        check_en("rej_a", 1'b1, 1'b0, 1'b0);
        tick();
        req_2 = 1'b0;
        check("rej_b.reject_2", 32'(reject_2), 32'd1);
        check_en("rej_b", 1'b1, 1'b0, 1'b0);
        tick();
        check("rej_c.reject_2", 32'(reject_2), 32'd0);
        check_en("rej_c", 1'b1, 1'b0, 1'b0);

        // 4: tie from PARK_1 goes to side 2, then done hands over directly
        req_1 = 1'b1; data_1 = 8'd10;
        req_2 = 1'b1; data_2 = 8'd180;
        tick();
        check_en("tie", 1'b0, 1'b1, 1'b1);
        check("tie.data_out", 32'(data_out), 32'd180);
        req_2 = 1'b0; done = 1'b1;
        tick();
        done = 1'b0;
        check_en("handover", 1'b1, 1'b0, 1'b1);
        check("handover.data_out", 32'(data_out), 32'd10);

        // 5: side 1 holds without done; side 2 preempts 4 edges after grant
        req_2 = 1'b1; data_2 = 8'd50;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_en("hold", 1'b1, 1'b0, 1'b1);
            check("hold.data_out", 32'(data_out), 32'd10);
        end
        tick();
        req_1 = 1'b0;
        check_en("preempt", 1'b0, 1'b1, 1'b1);
        check("preempt.data_out", 32'(data_out), 32'd50);

        // 6: asynchronous reset between edges while in BUSY_2
        #3 reset_n = 1'b0;
        #1;
        check_en("async_rst", 1'b1, 1'b0, 1'b0);
        check("async_rst.data_out", 32'(data_out), 32'd0);
        req_2 = 1'b0;
        #2 reset_n = 1'b1;
        tick();
        check_en("post_rst", 1'b1, 1'b0, 1'b0);
        check("post_rst.data_out", 32'(data_out), 32'd0);

        // LIMIT+1 on side 1 is rejected and does not grant
        req_1 = 1'b1; data_1 = 8'd201;
        tick();
        req_1 = 1'b0;
        check("rej201.reject_1", 32'(reject_1), 32'd1);
        check_en("rej201", 1'b1, 1'b0, 1'b0);
        tick();
        check("rej201_end.reject_1", 32'(reject_1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
